ahb_sram_responder: RTL and testbench
=====================================

# ahb_sram_responder

- AHB-Lite subordinate (responder) that terminates the manager-side transfers described by the `amba_ahb_pkg` request/response structs.
- Backs a word-organised flop memory with configurable wait states.
- Returns a two-cycle ERROR response for illegal accesses.
- Sits behind the AHB decoder/mux as a scratchpad or register-bank endpoint.

## Interface
Parameters:
- MEM_WORDS, 256: memory depth in AHB_DATA_WIDTH words; power of two, ≥ 4.
- WAIT_STATES, 0: data-phase wait cycles inserted per valid transfer, 0..15.

Ports:
- hclk  in  1  clock; one clock domain.
- hreset  in  1  reset, asynchronous, active-high.
- ahb_mosi_i  in  s_ahb_mosi_t  manager request (address/control/write data, hsel).
- hready_i  in  1  bus-level HREADY from the interconnect.
- ahb_miso_o  out  s_ahb_miso_t  response (hrdata, hready, hresp, hexokay).

## Operation
- Address phase is accepted when hsel && hready_i && htrans ∈ {NONSEQUENTIAL, SEQUENTIAL}.
  - On acceptance, register haddr, hsize, hwrite, hexcl, hmaster and an error flag.
- IDLE or BUSY transfers, and any cycle with hsel=0, produce a zero-wait OKAY response (hready=1, hresp=0).
- Error flag is set when any of these hold:
  - word offset haddr[AW-1:2] ≥ MEM_WORDS, with AW = AHB_ADDR_WIDTH;
  - hsize > AHB_SZ_WORD;
  - haddr is not aligned to hsize.
- Data-phase FSM:
  - DP_IDLE (hready=1, hresp=0):
    - accepted valid transfer with error → DP_ERR1;
    - accepted valid transfer, no error, WAIT_STATES>0 → DP_WAIT with counter=WAIT_STATES-1;
    - accepted valid transfer, no error, WAIT_STATES=0 → complete in this data cycle and stay in DP_IDLE.
  - DP_WAIT (hready=0): counter decrements; at 0 → DP_DONE.
  - DP_DONE (hready=1): transfer completes. Next state as for DP_IDLE, since a new address phase may be accepted in this cycle.
  - DP_ERR1 (hready=0, hresp=1) → DP_ERR2.
  - DP_ERR2 (hready=1, hresp=1): a new address phase may be accepted here; next state as for DP_IDLE.
- Write:
  - hwdata is sampled in the completing data cycle (hready_o=1).
  - Byte lanes are selected by hsize/haddr[1:0], little-endian.
  - Memory is updated at that clock edge.
- Read:
  - hrdata = mem[registered word address] during the completing cycle; 0 in all other cycles.
  - Read-after-write back-to-back returns the new data, because the write lands at the edge before the read data phase.
- Errored transfers never modify memory.

## Timing
- Reset values: hready=1, hresp=0, hrdata=0, hexokay=0; FSM=DP_IDLE; counter=0; exclusive monitor invalid. Memory is not reset.
- Latency: each valid transfer takes WAIT_STATES+1 data-phase cycles. With WAIT_STATES=0, transfers stream back-to-back at one per cycle.
- Address phase is never accepted while hready_i=0, whether this or another subordinate is stalling.
- Reset asserted mid-transfer: the transfer is abandoned, a pending write is not performed, and outputs return to reset values immediately.

## Configuration
- AHB_SRAM_EXCL_EN defined:
  - One exclusive monitor holds valid, hmaster and word address.
  - Exclusive read sets the monitor and returns hexokay=1.
  - Exclusive write with matching master and address performs the write, returns hexokay=1 and clears the monitor.
  - Any other exclusive write is suppressed and returns hexokay=0 with hresp=OKAY.
  - Any non-exclusive write to the monitored word clears the monitor.
  - hexokay is driven only in the completing cycle.
- Not defined: hexcl is ignored, exclusive writes behave as normal writes, hexokay is constant 0.

## Structure
- Add to amba_ahb_pkg:
  - AHB_RESP_OKAY=0 and AHB_RESP_ERROR=1 constants;
  - ahb_dp_state_t enum (DP_IDLE, DP_WAIT, DP_DONE, DP_ERR1, DP_ERR2);
  - a byte-strobe function taking hsize and haddr[1:0].
- Sub-module ahb_excl_monitor, instantiated only under AHB_SRAM_EXCL_EN.

## Test plan
- WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10, then back-to-back read of 0x10 → hready stays 1, hrdata=0xDEADBEEF in the second data cycle.
- WAIT_STATES=3: word read → hready low exactly 3 cycles, then high with data; the next address is held until then.
- Byte write 0xAA to 0x13 over 0x11223344, then word read → 0xAA223344.
- Read of word offset MEM_WORDS, and halfword at 0x01 → each gives hready=0/hresp=1, then hready=1/hresp=1, hrdata=0; memory unchanged.
- Reset asserted during DP_WAIT of a write → hready=1 immediately; a subsequent read returns the old data.
- Exclusive access (macro on), each case giving the stated hexokay:
  - master 2 exclusive read then exclusive write of 0x20 → hexokay=1;
  - repeat with an intervening normal write to 0x20 from master 1 → hexokay=0 and memory holds master 1's data.

Source files
------------

// File: rtl/amba_ahb_pkg.sv
// rtl/amba_ahb_pkg.sv - AHB-Lite bus types, constants and byte-lane helper
// Purpose: shared manager/subordinate request and response structs, transfer
//          and size encodings, response codes, the SRAM responder data-phase
//          state enum and a little-endian byte-strobe function.
// Ports:   none (package).
package amba_ahb_pkg;

  localparam int AHB_ADDR_WIDTH   = 32;
  localparam int AHB_DATA_WIDTH   = 32;
  localparam int AHB_MASTER_WIDTH = 4;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam logic [2:0] AHB_SZ_BYTE = 3'd0;
  localparam logic [2:0] AHB_SZ_HALF = 3'd1;
  localparam logic [2:0] AHB_SZ_WORD = 3'd2;

  localparam logic AHB_RESP_OKAY  = 1'b0;
  localparam logic AHB_RESP_ERROR = 1'b1;

  typedef struct packed {
    logic                        hsel;
    logic [AHB_ADDR_WIDTH-1:0]   haddr;
    logic [1:0]                  htrans;
    logic                        hwrite;
    logic [2:0]                  hsize;
    logic                        hexcl;
    logic [AHB_MASTER_WIDTH-1:0] hmaster;
    logic [AHB_DATA_WIDTH-1:0]   hwdata;
  } s_ahb_mosi_t;

  typedef struct packed {
    logic [AHB_DATA_WIDTH-1:0] hrdata;
    logic                      hready;
    logic                      hresp;
    logic                      hexokay;
  } s_ahb_miso_t;

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_WAIT,
    DP_DONE,
    DP_ERR1,
    DP_ERR2
  } ahb_dp_state_t;

  // Little-endian lane enables for a 32-bit data bus.
  function automatic logic [3:0] ahb_byte_strb(input logic [2:0] hsize,
                                               input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (hsize)
      AHB_SZ_BYTE: strb = 4'b0001 << addr_lo;
      AHB_SZ_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:     strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_sram_responder_if.sv
// rtl/ahb_sram_responder_if.sv - AHB-Lite subordinate port bundle
// Purpose: groups the request struct, bus-level HREADY and response struct.
// Signals: ahb_mosi_i (manager request), hready_i (interconnect HREADY),
//          ahb_miso_o (subordinate response).
// Modports: master drives request/hready_i, slave drives the response.
interface ahb_sram_responder_if;

  amba_ahb_pkg::s_ahb_mosi_t ahb_mosi_i;
  logic                      hready_i;
  amba_ahb_pkg::s_ahb_miso_t ahb_miso_o;

  modport master (output ahb_mosi_i, output hready_i, input  ahb_miso_o);
  modport slave  (input  ahb_mosi_i, input  hready_i, output ahb_miso_o);

endinterface

// File: rtl/ahb_sram_responder_excl.sv
// rtl/ahb_sram_responder_excl.sv - single-entry exclusive access monitor
// Purpose: tracks one (master, word) reservation set by an exclusive read.
// Ports:   hclk/hreset clock and async active-high reset;
//          i_rd_excl/i_wr_excl/i_wr_norm completing-cycle transfer strobes;
//          i_master/i_word identify the completing transfer;
//          o_match reservation valid and matching master and word.
// Built only when AHB_SRAM_EXCL_EN is defined.
module ahb_excl_monitor #(
  parameter int WORD_W = 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              i_rd_excl,
  input  logic              i_wr_excl,
  input  logic              i_wr_norm,
  input  logic [3:0]        i_master,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_match
);

  logic              r_valid;
  logic [3:0]        r_master;
  logic [WORD_W-1:0] r_word;
  logic              w_word_hit;

  assign w_word_hit = r_valid && (r_word == i_word);
  assign o_match    = w_word_hit && (r_master == i_master);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_valid  <= 1'b0;
      r_master <= '0;
      r_word   <= '0;
    end else if (i_rd_excl) begin
      r_valid  <= 1'b1;
      r_master <= i_master;
      r_word   <= i_word;
    end else if ((i_wr_excl && o_match) || (i_wr_norm && w_word_hit)) begin
      // A successful exclusive store consumes the reservation; any plain
      // store to the reserved word breaks it regardless of master.
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB-Lite SRAM subordinate with wait states
// Purpose: terminates AHB-Lite transfers into a word-organised flop memory,
//          inserting WAIT_STATES data-phase stalls and a two-cycle ERROR
//          response for out-of-range, oversize or misaligned accesses.
// Ports:   hclk   clock
//          hreset asynchronous active-high reset
//          bus    slave modport: ahb_mosi_i, hready_i in; ahb_miso_o out
// Option:  AHB_SRAM_EXCL_EN enables the exclusive access monitor.
module ahb_sram_responder
  import amba_ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_sram_responder_if.slave  bus
);

  localparam int         AW       = AHB_ADDR_WIDTH;
  localparam int         WW       = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  s_ahb_mosi_t   w_req;
  logic          w_accept;
  logic          w_err;
  ahb_dp_state_t r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_pend, w_pend_nxt;
  logic          w_take;
  logic          w_hready_o;
  logic          w_hresp_o;
  logic [WW-1:0] r_word;
  logic [1:0]    r_lane;
  logic [2:0]    r_size;
  logic          r_write;
  logic          w_complete;
  logic          w_wr_allow;
  logic          w_exokay;
  logic          w_mem_we;
  logic [3:0]    w_strb;
  logic [AHB_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  assign w_req    = bus.ahb_mosi_i;
  assign w_accept = w_req.hsel && bus.hready_i &&
                    ((w_req.htrans == AHB_TRANS_NONSEQ) || (w_req.htrans == AHB_TRANS_SEQ));
  assign w_err    = (w_req.haddr[AW-1:2] >= (AW-2)'(MEM_WORDS)) ||
                    (w_req.hsize > AHB_SZ_WORD) ||
                    ((w_req.hsize == AHB_SZ_HALF) && w_req.haddr[0]) ||
                    ((w_req.hsize == AHB_SZ_WORD) && (w_req.haddr[1:0] != 2'b00));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= DP_IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 1'b0;
      r_word  <= '0;
      r_lane  <= 2'b00;
      r_size  <= AHB_SZ_BYTE;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      if (w_accept) begin
        r_word  <= w_req.haddr[WW+1:2];
        r_lane  <= w_req.haddr[1:0];
        r_size  <= w_req.hsize;
        r_write <= w_req.hwrite;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = 1'b0;
    w_take      = 1'b0;
    w_hready_o  = 1'b1;
    w_hresp_o   = AHB_RESP_OKAY;
    case (r_state)
      DP_WAIT: begin
        w_hready_o = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = DP_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DP_ERR1: begin
        w_hready_o  = 1'b0;
        w_hresp_o   = AHB_RESP_ERROR;
        w_state_nxt = DP_ERR2;
      end
      DP_ERR2: begin
        w_hresp_o = AHB_RESP_ERROR;
        w_take    = 1'b1;
      end
      default: w_take = 1'b1;
    endcase
    // Every state that shows hready=1 can overlap the next address phase.
    if (w_take) begin
      w_state_nxt = DP_IDLE;
      if (w_accept) begin
        if (w_err) begin
          w_state_nxt = DP_ERR1;
        end else if (WAIT_STATES > 0) begin
          w_state_nxt = DP_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end else begin
          w_pend_nxt = 1'b1;
        end
      end
    end
  end

  // Zero-wait transfers complete in DP_IDLE the cycle after acceptance.
  assign w_complete = ((r_state == DP_IDLE) && r_pend) || (r_state == DP_DONE);

`ifdef AHB_SRAM_EXCL_EN
  logic       r_excl;
  logic [3:0] r_master;
  logic       w_mon_match;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_excl   <= 1'b0;
      r_master <= '0;
    end else if (w_accept) begin
      r_excl   <= w_req.hexcl;
      r_master <= w_req.hmaster;
    end
  end

  ahb_excl_monitor #(.WORD_W(WW)) u_excl_monitor (
    .hclk      (hclk),
    .hreset    (hreset),
    .i_rd_excl (w_complete && !r_write && r_excl),
    .i_wr_excl (w_complete && r_write && r_excl),
    .i_wr_norm (w_complete && r_write && !r_excl),
    .i_master  (r_master),
    .i_word    (r_word),
    .o_match   (w_mon_match)
  );

  assign w_wr_allow = !r_excl || w_mon_match;
  assign w_exokay   = w_complete && r_excl && (!r_write || w_mon_match);
`else
  logic w_unused_excl;
  assign w_unused_excl = ^{w_req.hexcl, w_req.hmaster};
  assign w_wr_allow    = 1'b1;
  assign w_exokay      = 1'b0;
`endif

  assign w_strb   = ahb_byte_strb(r_size, r_lane);
  // Reset gating keeps an abandoned write from landing at a reset edge.
  assign w_mem_we = w_complete && r_write && w_wr_allow && !hreset;

  always_ff @(posedge hclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          r_mem[r_word][8*b +: 8] <= w_req.hwdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.ahb_miso_o.hrdata  = (w_complete && !r_write) ? r_mem[r_word] : '0;
    bus.ahb_miso_o.hready  = w_hready_o;
    bus.ahb_miso_o.hresp   = w_hresp_o;
    bus.ahb_miso_o.hexokay = w_exokay;
  end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb/tb_ahb_sram_responder.sv - self-checking bench for ahb_sram_responder
module tb_ahb_sram_responder;
  import amba_ahb_pkg::*;

  localparam int MW = 64;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        excl;
    logic [3:0]  master;
    logic [1:0]  trans;
  } txn_t;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    logic        exokay;
    int          lat;
  } exp_t;

  logic hclk;
  logic hreset;
  int   sel;
  int   n_chk;
  int   n_fail;
  int   n_id;

  s_ahb_mosi_t req;
  s_ahb_mosi_t idle_req;
  s_ahb_miso_t rsp;

  txn_t        q_txn[$];
  exp_t        q_exp[$];
  logic [31:0] bm [2][MW];
  logic        mon_v;
  logic [3:0]  mon_m;
  int          mon_w;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  ahb_sram_responder_if if0();
  ahb_sram_responder_if if3();

  ahb_sram_responder #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .bus(if0.slave));
  ahb_sram_responder #(.MEM_WORDS(MW), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .bus(if3.slave));

  assign idle_req     = '0;
  assign if0.hready_i = if0.ahb_miso_o.hready;
  assign if3.hready_i = if3.ahb_miso_o.hready;

  always_comb begin
    if0.ahb_mosi_i = (sel == 0) ? req : idle_req;
    if3.ahb_mosi_i = (sel == 1) ? req : idle_req;
    rsp            = (sel == 0) ? if0.ahb_miso_o : if3.ahb_miso_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Queue a transfer and push its expected response from the bench model.
  task automatic add(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input logic ex, input logic [3:0] mst,
                     input logic [1:0] tr);
    txn_t t;
    exp_t e;
    logic [3:0] strb;
    logic wr_ok;
    int w;
    t = '{write: wr, addr: a, size: sz, wdata: wd, excl: ex, master: mst, trans: tr};
    q_txn.push_back(t);
    e.id     = n_id;
    n_id++;
    e.err    = (a[31:2] >= 30'(MW)) || (sz > 3'd2) || ((sz == 3'd1) && a[0]) ||
               ((sz == 3'd2) && (a[1:0] != 2'b00));
    e.lat    = e.err ? 2 : ((sel == 1) ? 4 : 1);
    e.rdata  = 32'h0;
    e.exokay = 1'b0;
    if (!e.err) begin
      w = int'(a[7:2]);
      case (sz)
        3'd0:    strb = 4'b0001 << a[1:0];
        3'd1:    strb = a[1] ? 4'b1100 : 4'b0011;
        default: strb = 4'b1111;
      endcase
      wr_ok = 1'b1;
`ifdef AHB_SRAM_EXCL_EN
      if (sel == 0) begin
        if (ex && !wr) begin
          mon_v = 1'b1; mon_m = mst; mon_w = w; e.exokay = 1'b1;
        end else if (ex && wr) begin
          wr_ok    = mon_v && (mon_m == mst) && (mon_w == w);
          e.exokay = wr_ok;
          if (wr_ok) mon_v = 1'b0;
        end else if (wr && mon_v && (mon_w == w)) begin
          mon_v = 1'b0;
        end
      end
`endif
      if (wr && wr_ok) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) bm[sel][w][8*b +: 8] = wd[8*b +: 8];
      end
      if (!wr) e.rdata = bm[sel][w];
    end
    q_exp.push_back(e);
  endtask

  // Pipelined AHB driver: address phase of the next transfer overlaps the
  // data phase of the current one and is held while hready is low.
  task automatic run_seq();
    txn_t dp;
    exp_t e;
    bit   dp_v;
    bit   rdy;
    int   cyc;
    int   guard;
    dp_v  = 1'b0;
    cyc   = 0;
    guard = 0;
    @(posedge hclk); #1;
    while ((q_txn.size() > 0 || dp_v) && guard < 300) begin
      if (q_txn.size() > 0) begin
        req.hsel    = 1'b1;
        req.haddr   = q_txn[0].addr;
        req.htrans  = q_txn[0].trans;
        req.hwrite  = q_txn[0].write;
        req.hsize   = q_txn[0].size;
        req.hexcl   = q_txn[0].excl;
        req.hmaster = q_txn[0].master;
      end else begin
        req.hsel   = 1'b0;
        req.htrans = AHB_TRANS_IDLE;
      end
      req.hwdata = dp_v ? dp.wdata : 32'h0;
      @(negedge hclk);
      rdy = rsp.hready;
      if (dp_v) begin
        cyc++;
        if (q_exp.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else if (!rdy) begin
          chk($sformatf("t%0d_stall_resp", q_exp[0].id), 32'(rsp.hresp), 32'(q_exp[0].err));
          chk($sformatf("t%0d_stall_rdata", q_exp[0].id), rsp.hrdata, 32'h0);
        end else begin
          e = q_exp.pop_front();
          chk($sformatf("t%0d_latency", e.id), 32'(cyc), 32'(e.lat));
          chk($sformatf("t%0d_hresp", e.id), 32'(rsp.hresp), 32'(e.err));
          chk($sformatf("t%0d_hrdata", e.id), rsp.hrdata, e.rdata);
          chk($sformatf("t%0d_hexokay", e.id), 32'(rsp.hexokay), 32'(e.exokay));
        end
      end
      @(posedge hclk); #1;
      if (rdy) begin
        dp_v = 1'b0;
        if (q_txn.size() > 0) begin
          dp   = q_txn.pop_front();
          dp_v = 1'b1;
          cyc  = 0;
        end
      end
      guard++;
    end
    if (q_txn.size() > 0 || dp_v) begin
      chk("sequence_timeout", 32'd0, 32'd1);
      q_txn.delete();
      q_exp.delete();
    end
    req = idle_req;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_id   = 0;
    mon_v  = 1'b0;
    mon_m  = '0;
    mon_w  = 0;
    sel    = 0;
    req    = '0;
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    sel = 0;
    #1;
    chk("rst0_hready", 32'(rsp.hready), 32'd1);
    chk("rst0_hresp", 32'(rsp.hresp), 32'd0);
    chk("rst0_hrdata", rsp.hrdata, 32'h0);
    chk("rst0_hexokay", 32'(rsp.hexokay), 32'd0);
    sel = 1;
    #1;
    chk("rst3_hready", 32'(rsp.hready), 32'd1);
    chk("rst3_hresp", 32'(rsp.hresp), 32'd0);
    chk("rst3_hrdata", rsp.hrdata, 32'h0);
    chk("rst3_hexokay", 32'(rsp.hexokay), 32'd0);
    hreset = 1'b0;
    sel    = 0;

    // Zero-wait streaming, read-after-write, byte and halfword lanes.
    add(1, 32'h10, AHB_SZ_WORD, 32'hDEADBEEF, 0, 0, AHB_TRANS_NONSEQ);
    add(0, 32'h10, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    add(1, 32'h14, AHB_SZ_WORD, 32'h11223344, 0, 0, AHB_TRANS_NONSEQ);
    add(1, 32'h17, AHB_SZ_BYTE, 32'hAA000000, 0, 0, AHB_TRANS_SEQ);
    add(0, 32'h14, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_SEQ);
    add(1, 32'h16, AHB_SZ_HALF, 32'hBEEF0000, 0, 0, AHB_TRANS_NONSEQ);
    add(0, 32'h14, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    run_seq();

    // Error responses: out of range, misaligned half, oversize; memory intact.
    add(0, 32'(MW * 4), AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    add(0, 32'h01, AHB_SZ_HALF, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    add(1, 32'h11, AHB_SZ_HALF, 32'h55555555, 0, 0, AHB_TRANS_NONSEQ);
    add(1, 32'h10, 3'd3, 32'h66666666, 0, 0, AHB_TRANS_NONSEQ);
    add(0, 32'h10, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    run_seq();

    // IDLE and BUSY with hsel high give a zero-wait OKAY.
    req.hsel   = 1'b1;
    req.htrans = AHB_TRANS_BUSY;
    @(negedge hclk);
    chk("busy_hready", 32'(rsp.hready), 32'd1);
    chk("busy_hresp", 32'(rsp.hresp), 32'd0);
    @(posedge hclk); #1;
    req.htrans = AHB_TRANS_IDLE;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("idle_hready", 32'(rsp.hready), 32'd1);
    chk("idle_hrdata", rsp.hrdata, 32'h0);
    req = idle_req;

    // Three wait states, back-to-back with held address phase.
    sel = 1;
    add(1, 32'h20, AHB_SZ_WORD, 32'h11111111, 0, 0, AHB_TRANS_NONSEQ);
    add(0, 32'h20, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    add(1, 32'h21, AHB_SZ_BYTE, 32'h0000CC00, 0, 0, AHB_TRANS_SEQ);
    add(0, 32'h20, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_SEQ);
    add(0, 32'h02, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    run_seq();

    // Reset during the wait states of a write abandons it.
    @(posedge hclk); #1;
    req.hsel   = 1'b1;
    req.haddr  = 32'h20;
    req.htrans = AHB_TRANS_NONSEQ;
    req.hwrite = 1'b1;
    req.hsize  = AHB_SZ_WORD;
    @(posedge hclk); #1;
    req.hsel   = 1'b0;
    req.htrans = AHB_TRANS_IDLE;
    req.hwdata = 32'h99999999;
    @(negedge hclk);
    chk("rstmid_stall", 32'(rsp.hready), 32'd0);
    #2;
    hreset = 1'b1;
    #1;
    chk("rstmid_hready", 32'(rsp.hready), 32'd1);
    chk("rstmid_hresp", 32'(rsp.hresp), 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    mon_v  = 1'b0;
    req    = idle_req;
    add(0, 32'h20, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_NONSEQ);
    run_seq();

    // Exclusive pairs; the model covers both builds.
    sel = 0;
    add(0, 32'h20, AHB_SZ_WORD, 32'h0, 1, 4'd2, AHB_TRANS_NONSEQ);
    add(1, 32'h20, AHB_SZ_WORD, 32'hCAFE0002, 1, 4'd2, AHB_TRANS_NONSEQ);
    add(0, 32'h20, AHB_SZ_WORD, 32'h0, 0, 4'd2, AHB_TRANS_NONSEQ);
    run_seq();
    add(0, 32'h20, AHB_SZ_WORD, 32'h0, 1, 4'd2, AHB_TRANS_NONSEQ);
    add(1, 32'h20, AHB_SZ_WORD, 32'h00000001, 0, 4'd1, AHB_TRANS_NONSEQ);
    add(1, 32'h20, AHB_SZ_WORD, 32'hBAD00002, 1, 4'd2, AHB_TRANS_NONSEQ);
    add(0, 32'h20, AHB_SZ_WORD, 32'h0, 0, 4'd1, AHB_TRANS_NONSEQ);
    run_seq();

    // Random word traffic on both responders.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      sel = i % 2;
      ra  = {24'h0, 6'($urandom_range(0, MW - 1)), 2'b00};
      add(1, ra, AHB_SZ_WORD, $urandom, 0, 0, AHB_TRANS_NONSEQ);
      add(0, ra, AHB_SZ_WORD, 32'h0, 0, 0, AHB_TRANS_SEQ);
      run_seq();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
